// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetcher (queue entry, FSM state, default depth).
// Defining FETCH_PREFETCH_ERR_EN adds a bus-error flag to every queue entry.
package fetch_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

    typedef struct packed {
`ifdef FETCH_PREFETCH_ERR_EN
        logic        err;
`endif
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous circular buffer with push, pop, flush and occupancy count.
// Flush wins over a same-cycle push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_entry,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: single-outstanding bus reader filling a DEPTH-entry queue.
// Optional FETCH_PREFETCH_ERR_EN adds err_i/instr_err_o; a bus error halts fetch until redirect.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [29:0] adr_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
`ifdef FETCH_PREFETCH_ERR_EN
    input  logic        err_i,
    output logic        instr_err_o,
`endif
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    fetch_state_e  r_state, w_state_next;
    logic [31:0]   r_pc, w_pc_next;
    logic          r_stb, w_stb_next;
    logic [29:0]   r_adr, w_adr_next;

    logic          w_bus_err;
    logic          w_done;
    logic          w_halted;
    logic          w_push;
    logic          w_pop;
    logic          w_can_issue;
    logic          w_issue;
    logic [31:0]   w_issue_pc;
    logic [31:0]   w_redirect_pc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

`ifdef FETCH_PREFETCH_ERR_EN
    logic r_halt, w_halt_next;
    assign w_bus_err = err_i;
    assign w_halted  = r_halt;
`else
    assign w_bus_err = 1'b0;
    assign w_halted  = 1'b0;
`endif

    assign w_done        = ack_i | w_bus_err;
    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_push        = (r_state == StBusy) && w_done && !redirect_i;
    assign w_pop         = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_count_next  = redirect_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    // Counting the in-flight push here keeps count + outstanding <= DEPTH.
    assign w_can_issue   = w_count_next < CW'(DEPTH);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.instr = dat_i;
        w_push_entry.pc    = r_pc;
`ifdef FETCH_PREFETCH_ERR_EN
        w_push_entry.err   = err_i;
        if (err_i) begin
            w_push_entry.instr = '0;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_stb_next   = r_stb;
        w_adr_next   = r_adr;
        w_issue      = 1'b0;
        w_issue_pc   = r_pc;
        case (r_state)
            StIdle: begin
                if (redirect_i) begin
                    w_issue    = 1'b1;
                    w_issue_pc = w_redirect_pc;
                end else if (!w_halted && w_can_issue) begin
                    w_issue = 1'b1;
                end
            end
            StBusy: begin
                if (redirect_i && w_done) begin
                    w_issue    = 1'b1;
                    w_issue_pc = w_redirect_pc;
                end else if (redirect_i) begin
                    w_state_next = StFlush;
                    w_pc_next    = w_redirect_pc;
                end else if (w_bus_err) begin
                    w_state_next = StIdle;
                    w_stb_next   = 1'b0;
                end else if (ack_i) begin
                    if (w_can_issue) begin
                        w_issue    = 1'b1;
                        w_issue_pc = next_pc(r_pc);
                    end else begin
                        w_state_next = StIdle;
                        w_stb_next   = 1'b0;
                        w_pc_next    = next_pc(r_pc);
                    end
                end
            end
            StFlush: begin
                if (w_done) begin
                    w_issue    = 1'b1;
                    w_issue_pc = redirect_i ? w_redirect_pc : r_pc;
                end else if (redirect_i) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_stb_next   = 1'b0;
            end
        endcase
        if (w_issue) begin
            w_state_next = StBusy;
            w_stb_next   = 1'b1;
            w_adr_next   = w_issue_pc[31:2];
            w_pc_next    = w_issue_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC_W;
            r_stb   <= 1'b0;
            r_adr   <= RESET_PC[31:2];
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_stb   <= w_stb_next;
            r_adr   <= w_adr_next;
        end
    end

`ifdef FETCH_PREFETCH_ERR_EN
    always_comb begin
        w_halt_next = r_halt;
        if (redirect_i) begin
            w_halt_next = 1'b0;
        end else if (w_push && err_i) begin
            w_halt_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= w_halt_next;
        end
    end

    assign instr_err_o = w_head.err;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign stb_o         = r_stb;
    assign adr_o         = r_adr;
    assign instr_valid_o = (w_count != '0);
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomised self-checking bench for fetch_prefetch against a word-index ROM and a stream model.
// Covers the FETCH_PREFETCH_ERR_EN error path when that macro is defined.
`timescale 1ns/1ps
module tb_fetch_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] adr;
    logic        stb;
    logic [31:0] dat;
    logic        ack;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic        ready;
`ifdef FETCH_PREFETCH_ERR_EN
    logic        err;
    logic        instr_err;
    logic        err_q;
    logic        err_en = 1'b0;
    logic [29:0] err_adr = 30'h8;
    logic        got_err_q [$];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .adr_o         (adr),
        .stb_o         (stb),
        .dat_i         (dat),
        .ack_i         (ack),
`ifdef FETCH_PREFETCH_ERR_EN
        .err_i         (err),
        .instr_err_o   (instr_err),
`endif
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (valid),
        .instr_ready_i (ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus slave: ROM with mem[i] = i, registered ack after a random number of wait cycles.
    logic        ack_q;
    logic [31:0] dat_q;
    logic        force_ack = 1'b0;
    int unsigned stall_pct = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= 32'hDEAD_BEEF;
`ifdef FETCH_PREFETCH_ERR_EN
            err_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef FETCH_PREFETCH_ERR_EN
            err_q <= 1'b0;
            if (stb && !ack_q && !err_q && ($urandom_range(99) >= stall_pct)) begin
                if (err_en && adr == err_adr) err_q <= 1'b1;
                else ack_q <= 1'b1;
                dat_q <= {2'b00, adr};
            end
`else
            if (stb && !ack_q && ($urandom_range(99) >= stall_pct)) begin
                ack_q <= 1'b1;
                dat_q <= {2'b00, adr};
            end
`endif
        end
    end

    assign ack = ack_q | force_ack;
    assign dat = dat_q;
`ifdef FETCH_PREFETCH_ERR_EN
    assign err = err_q;
`endif

    // Reference model: delivered words form a consecutive PC run from reset or the last redirect.
    logic [31:0] exp_pc;
    logic        prev_hold = 1'b0;
    logic [29:0] prev_adr;
    int          n_acks = 0;
    logic [31:0] got_pc_q [$];
    logic [31:0] got_instr_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    = RESET_PC;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("stb_held", {31'd0, stb}, 32'd1);
                check_eq("adr_held", {2'b00, adr}, {2'b00, prev_adr});
            end
`ifdef FETCH_PREFETCH_ERR_EN
            prev_hold = stb && !ack && !err;
`else
            prev_hold = stb && !ack;
`endif
            prev_adr = adr;
            if (stb && ack) n_acks++;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (valid && ready) begin
                check_eq("deliv_pc", instr_pc, exp_pc);
`ifdef FETCH_PREFETCH_ERR_EN
                check_eq("deliv_err", {31'd0, instr_err},
                         {31'd0, err_en && exp_pc == {err_adr, 2'b00}});
                if (!(err_en && exp_pc == {err_adr, 2'b00}))
                    check_eq("deliv_instr", instr, {2'b00, exp_pc[31:2]});
                got_err_q.push_back(instr_err);
`else
                check_eq("deliv_instr", instr, {2'b00, exp_pc[31:2]});
`endif
                got_pc_q.push_back(instr_pc);
                got_instr_q.push_back(instr);
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_pc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic found;
        int   idx;
        int   n_rand;

        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stb", {31'd0, stb}, 32'd0);
        check_eq("rst_adr", {2'b00, adr}, RESET_PC >> 2);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);

        // Release with a spurious ack in the first cycle; it must be ignored.
        n_acks    = 0;
        rst_n     = 1'b1;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check_eq("first_stb", {31'd0, stb}, 32'd1);
        check_eq("first_adr", {2'b00, adr}, RESET_PC >> 2);

        // Consumer stalled: the queue fills with exactly DEPTH words, then fetch stops.
        repeat (19) step();
        check_eq("full_acks", n_acks, DEPTH);
        check_eq("full_stb", {31'd0, stb}, 32'd0);
        check_eq("full_valid", {31'd0, valid}, 32'd1);
        check_eq("full_head_pc", instr_pc, 32'h100);
        check_eq("full_head_instr", instr, 32'h40);

        ready = 1'b1;
        wait_got(3, 40, ok);
        check_eq("resume_ok", {31'd0, ok}, 32'd1);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("resume_pc", got_pc_q[i], 32'h100 + 32'(4 * i));
                check_eq("resume_instr", got_instr_q[i], 32'h40 + 32'(i));
            end
        end

        // Redirect while the fetch of 0x10C is outstanding.
        do_redirect(32'h100);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (stb && adr == 30'h43 && !ack) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("find_10c", {31'd0, found}, 32'd1);
        do_redirect(32'h200);
        idx = got_pc_q.size();
        wait_got(idx + 1, 40, ok);
        check_eq("redir_ok", {31'd0, ok}, 32'd1);
        if (ok) begin
            check_eq("redir_pc", got_pc_q[idx], 32'h200);
            check_eq("redir_instr", got_instr_q[idx], 32'h80);
        end

        // Fill the queue, pop once (count 3), then redirect on a cycle that also pops.
        ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!stb && valid) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("fill_again", {31'd0, found}, 32'd1);
        ready = 1'b1;
        step();
        check_eq("cnt3_valid", {31'd0, valid}, 32'd1);
        do_redirect(32'h300);
        check_eq("flush_empty", {31'd0, valid}, 32'd0);
        idx = got_pc_q.size();
        wait_got(idx + 1, 40, ok);
        check_eq("flush_ok", {31'd0, ok}, 32'd1);
        if (ok) begin
            check_eq("flush_pc", got_pc_q[idx], 32'h300);
            check_eq("flush_instr", got_instr_q[idx], 32'hC0);
        end

        // Address wrap; low redirect bits must be ignored.
        do_redirect(32'hFFFF_FFFB);
        idx   = got_pc_q.size();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (stb && adr == 30'h0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("wrap_adr0", {31'd0, found}, 32'd1);
        wait_got(idx + 3, 40, ok);
        check_eq("wrap_ok", {31'd0, ok}, 32'd1);
        if (ok) begin
            check_eq("wrap_pc0", got_pc_q[idx], 32'hFFFF_FFF8);
            check_eq("wrap_pc1", got_pc_q[idx + 1], 32'hFFFF_FFFC);
            check_eq("wrap_pc2", got_pc_q[idx + 2], 32'h0);
            check_eq("wrap_instr1", got_instr_q[idx + 1], 32'h3FFF_FFFF);
            check_eq("wrap_instr2", got_instr_q[idx + 2], 32'h0);
        end

`ifdef FETCH_PREFETCH_ERR_EN
        // Bus error at 0x20: flagged entry, then fetch stays stopped until redirect.
        err_en = 1'b1;
        do_redirect(32'h18);
        idx = got_pc_q.size();
        wait_got(idx + 3, 40, ok);
        check_eq("err_ok", {31'd0, ok}, 32'd1);
        if (ok) begin
            check_eq("err_pc", got_pc_q[idx + 2], 32'h20);
            check_eq("err_flag", {31'd0, got_err_q[idx + 2]}, 32'd1);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stb) found = 1'b1;
            step();
        end
        check_eq("err_halt", {31'd0, found}, 32'd0);
        err_en = 1'b0;
        do_redirect(32'h100);
        idx = got_pc_q.size();
        wait_got(idx + 1, 40, ok);
        check_eq("err_resume", ok ? got_pc_q[idx] : 32'hFFFF_FFFF, 32'h100);
`endif

        // Random traffic: consumer stalls, bus wait states, occasional redirects.
        stall_pct = 30;
        idx       = got_pc_q.size();
        for (int i = 0; i < 1500; i++) begin
            ready       = ($urandom_range(99) < 70);
            redirect    = ($urandom_range(99) < 3);
            redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                   : $urandom;
            step();
        end
        redirect = 1'b0;
        ready    = 1'b1;
        repeat (20) step();
        n_rand = got_pc_q.size() - idx;
        check_eq("rand_progress", {31'd0, n_rand > 50}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address of the first fetch after reset.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adr_o  out  30  bus word address (byte PC[31:2]).
REQ-006 SHALL have port stb_o  out  1  bus read strobe.
REQ-007 SHALL have port dat_i  in  32  bus read data, valid when ack_i=1.
REQ-008 SHALL have port ack_i  in  1  bus acknowledge.
REQ-009 SHALL have port redirect_i  in  1  flush and restart fetch at redirect_pc_i.
REQ-010 SHALL have port redirect_pc_i  in  32  new byte PC; bits [1:0] ignored.
REQ-011 SHALL have port instr_o / instr_pc_o  out  32 each  queue head word and its byte PC.
REQ-012 SHALL have port instr_valid_o  out  1 and instr_ready_i  in  1  consumer valid/ready handshake.

Function
REQ-013 SHALL keep at most one bus transaction outstanding; stb_o and adr_o registered and held stable from assertion until the ack_i cycle.
REQ-014 SHALL, at the edge sampling ack_i=1, either deassert stb_o or present the next address with stb_o held high (back-to-back throughput: one word per 2 cycles against a 1-cycle-ack slave).
REQ-015 SHALL issue a new request only when queue count + outstanding < DEPTH; an ack therefore never meets a full queue.
REQ-016 SHALL use an FSM with states IDLE (no request), BUSY (request outstanding, data kept), FLUSH (request outstanding, data discarded).
REQ-017 SHALL transition IDLE->BUSY on issue; BUSY->BUSY/IDLE on ack (depending on REQ-015); BUSY->FLUSH on redirect_i; FLUSH->BUSY on ack (issuing at the redirect PC); FLUSH->FLUSH on redirect_i (PC updated to latest).
REQ-018 SHALL push {dat_i, PC} into the queue on ack_i in BUSY and advance PC by 4, wrapping 32'hFFFF_FFFC->32'h0000_0000.
REQ-019 SHALL drive instr_valid_o = (count != 0), instr_o/instr_pc_o from the head; pop when instr_valid_o && instr_ready_i.
REQ-020 SHALL allow push and pop in the same cycle with count unchanged.
REQ-021 SHALL, on redirect_i, empty the queue, load PC from {redirect_pc_i[31:2],2'b00}, and ignore any same-cycle pop or push; a redirect in IDLE issues at the new PC on the next edge.

Reset
REQ-022 SHALL, while rst_ni=0, force stb_o=0, adr_o=RESET_PC[31:2], count=0, instr_valid_o=0, state IDLE.
REQ-023 SHALL assert stb_o with adr_o=RESET_PC[31:2] at the first rising edge after rst_ni releases.
REQ-024 SHALL treat reset mid-transaction as abandoning it; an ack_i arriving in the first cycle after release SHALL be ignored (state IDLE).

Configuration
REQ-025 SHALL implement macro FETCH_PREFETCH_ERR_EN: when defined, adds input err_i (1) and output instr_err_o (1); err_i terminates a transaction like ack_i and pushes an entry with error flag set, dat ignored, and fetching stops (IDLE) until redirect_i.
REQ-026 SHALL, without FETCH_PREFETCH_ERR_EN, have neither port and store no error flag.

Structure
REQ-027 SHALL place the queue entry type (instr, pc, optional err), FSM state encoding and default DEPTH in shared package fetch_pkg.
REQ-028 SHALL implement the queue as sub-module fetch_fifo (synchronous, DEPTH entries, push/pop/flush, count).

Verification
REQ-029 SHALL cover reset release with RESET_PC=0x100, 1-cycle-ack ROM holding mem[i]=i -> instr sequence 0x40,0x41,0x42 at PCs 0x100,0x104,0x108.
REQ-030 SHALL cover instr_ready_i=0 for 20 cycles, DEPTH=4 -> exactly 4 acks, stb_o then low, queue full; ready=1 resumes in order.
REQ-031 SHALL cover redirect_i to 0x200 while BUSY at 0x10C -> word from 0x10C discarded, next valid instr_pc_o=0x200, data mem[0x80].
REQ-032 SHALL cover redirect_i in same cycle as a pop with count=3 -> count 0 next cycle, no stale PC ever delivered.
REQ-033 SHALL cover PC 0xFFFF_FFFC -> next fetch adr_o=0.
REQ-034 SHALL cover, with FETCH_PREFETCH_ERR_EN, err_i at PC 0x20 -> entry with instr_err_o=1, stb_o stays 0 until redirect_i.
